// File: rtl/dealer_player_if.sv
// Hit/pass handshake between the blackjack core and the automated dealer.
// The core drives the master side and the dealer_player drives the slave side.
interface dealer_player_if;
  logic       turn_start;
  logic [7:0] hand_total;
  logic       soft_hand;
  logic       card_dealt;
  logic       hit;
  logic       pass;
  logic       busy;
  logic       done;
  logic       bust;
  logic       timeout_err;
  logic [2:0] card_count;

  modport master (
    output turn_start, hand_total, soft_hand, card_dealt,
    input  hit, pass, busy, done, bust, timeout_err, card_count
  );

  modport slave (
    input  turn_start, hand_total, soft_hand, card_dealt,
    output hit, pass, busy, done, bust, timeout_err, card_count
  );
endinterface

// File: rtl/dealer_player.sv
// Automated blackjack dealer: applies the dealer stand/hit policy each turn,
// pulses hit/pass and waits for the core to deal each requested card.
module dealer_player #(
  parameter int STAND_THRESH = 17,
  parameter int HIT_SOFT17   = 1,
  parameter int THINK_CYCLES = 4,
  parameter int WAIT_LIMIT   = 16,
  parameter int MAX_CARDS    = 5
) (
  input  logic           clk,
  input  logic           reset,
  dealer_player_if.slave dp
);
  localparam int TW = $clog2(THINK_CYCLES + 1);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [TW-1:0] THINK_LAST = TW'(THINK_CYCLES);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_LIMIT - 1);
  localparam logic [7:0]    STAND_T    = 8'(STAND_THRESH);
  localparam logic [2:0]    CARD_CAP   = 3'(MAX_CARDS);

  typedef enum logic [2:0] {
    IDLE, THINK, DECIDE, WAIT_CARD, DONE
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] think_cnt, think_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [2:0]    cards, cards_nx;
  logic          hit_q, hit_nx;
  logic          pass_q, pass_nx;
  logic          busy_q, busy_nx;
  logic          done_q, done_nx;
  logic          bust_q, bust_nx;
  logic          tmo_q, tmo_nx;
  logic          want_hit;

  assign want_hit = (dp.hand_total < STAND_T) ||
                    ((HIT_SOFT17 != 0) && (dp.hand_total == 8'd17) && dp.soft_hand);

  always_comb begin
    state_nx = state;
    think_nx = think_cnt;
    wait_nx  = wait_cnt;
    cards_nx = cards;
    hit_nx   = 1'b0;
    pass_nx  = 1'b0;
    bust_nx  = bust_q;
    tmo_nx   = tmo_q;
    case (state)
      IDLE, DONE: begin
        if (dp.turn_start) begin
          state_nx = THINK;
          think_nx = '0;
          cards_nx = 3'd2;
          bust_nx  = 1'b0;
          tmo_nx   = 1'b0;
        end
      end
      // Counting up to THINK_CYCLES inclusive lands the decision pulse
      // THINK_CYCLES+2 clocks after the turn_start / card_dealt edge.
      THINK: begin
        if (think_cnt == THINK_LAST) begin
          state_nx = DECIDE;
          think_nx = '0;
        end else begin
          think_nx = think_cnt + 1'b1;
        end
      end
      DECIDE: begin
        if (dp.hand_total > 8'd21) begin
          bust_nx  = 1'b1;
          state_nx = DONE;
        end else if (cards == CARD_CAP) begin
          pass_nx  = 1'b1;
          state_nx = DONE;
        end else if (want_hit) begin
          hit_nx   = 1'b1;
          wait_nx  = '0;
          state_nx = WAIT_CARD;
        end else begin
          pass_nx  = 1'b1;
          state_nx = DONE;
        end
      end
      // A card arriving on the expiry clock takes priority over the timeout.
      WAIT_CARD: begin
        if (dp.card_dealt) begin
          cards_nx = (cards == 3'd7) ? 3'd7 : cards + 1'b1;
          think_nx = '0;
          state_nx = THINK;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == THINK) || (state_nx == DECIDE) || (state_nx == WAIT_CARD);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      think_cnt <= '0;
      wait_cnt  <= '0;
      cards     <= 3'd0;
      hit_q     <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bust_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      think_cnt <= think_nx;
      wait_cnt  <= wait_nx;
      cards     <= cards_nx;
      hit_q     <= hit_nx;
      pass_q    <= pass_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      bust_q    <= bust_nx;
      tmo_q     <= tmo_nx;
    end
  end

  assign dp.hit         = hit_q;
  assign dp.pass        = pass_q;
  assign dp.busy        = busy_q;
  assign dp.done        = done_q;
  assign dp.bust        = bust_q;
  assign dp.timeout_err = tmo_q;
  assign dp.card_count  = cards;
endmodule

// File: tb/tb_dealer_player.sv
// Directed bench for dealer_player: expected hit/pass pulses are queued as
// stimulus is driven and matched by a monitor thread; status is checked inline.
module tb_dealer_player;
  localparam int THINK = 4;
  localparam int WLIM  = 16;
  localparam int LAT   = THINK + 2;

  typedef struct {
    logic        is_hit;
    int unsigned cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];

  dealer_player_if dp();

  dealer_player #(
    .STAND_THRESH(17), .HIT_SOFT17(1), .THINK_CYCLES(THINK),
    .WAIT_LIMIT(WLIM), .MAX_CARDS(5)
  ) dut (
    .clk(clk), .reset(reset), .dp(dp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic is_hit, input int unsigned c);
    ev_t e;
    e.is_hit = is_hit;
    e.cyc    = c;
    exp_q.push_back(e);
  endtask

  task automatic at_cycle(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_turn(output int unsigned t);
    @(negedge clk);
    dp.turn_start = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    dp.turn_start = 1'b0;
  endtask

  task automatic deal(output int unsigned d);
    @(negedge clk);
    dp.card_dealt = 1'b1;
    @(posedge clk);
    #1;
    d = cyc;
    dp.card_dealt = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic busy, input logic done,
                            input logic bust, input logic tmo, input logic [2:0] cc);
    chk({tag, "_busy"}, 32'(dp.busy), 32'(busy));
    chk({tag, "_done"}, 32'(dp.done), 32'(done));
    chk({tag, "_bust"}, 32'(dp.bust), 32'(bust));
    chk({tag, "_tmo"},  32'(dp.timeout_err), 32'(tmo));
    chk({tag, "_cards"}, 32'(dp.card_count), 32'(cc));
  endtask

  initial begin
    int unsigned t, d, p;
    dp.turn_start = 1'b0;
    dp.hand_total = 8'd0;
    dp.soft_hand  = 1'b0;
    dp.card_dealt = 1'b0;

    // pulse monitor: every hit/pass cycle must match the head of the queue
    fork
      forever begin
        @(negedge clk);
        if (reset && (dp.hit || dp.pass)) begin
          checks++;
          assert (!(dp.hit && dp.pass)) else begin
            errors++;
            $error("FAIL hit_pass_both: observed hit=%0b pass=%0b expected one", dp.hit, dp.pass);
          end
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse: observed hit=%0b pass=%0b at %0d expected none",
                   dp.hit, dp.pass, cyc);
          end
          if (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            assert (dp.hit === e.is_hit && cyc === e.cyc) else begin
              errors++;
              $error("FAIL pulse: observed hit=%0b at %0d expected hit=%0b at %0d",
                     dp.hit, cyc, e.is_hit, e.cyc);
            end
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", 32'(dp.hit), 32'd0);
    chk("rst_pass", 32'(dp.pass), 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: stand on 19
    dp.hand_total = 8'd19;
    pulse_turn(t);
    push(1'b0, t + LAT);
    at_cycle(t + 1);
    chk_status("t1_think", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    at_cycle(t + LAT + 1);
    chk_status("t1_end", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);

    // 2: hit on 12, card 3 clocks later brings 18, then stand
    dp.hand_total = 8'd12;
    pulse_turn(t);
    push(1'b1, t + LAT);
    at_cycle(t + LAT);
    chk_status("t2_wait", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    dp.hand_total = 8'd18;
    at_cycle(t + LAT + 2);
    deal(d);
    push(1'b0, d + LAT);
    at_cycle(d + 1);
    chk("t2_cards", 32'(dp.card_count), 32'd3);
    at_cycle(d + LAT + 1);
    chk_status("t2_end", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);

    // 3: soft 17 hits, dealt to 23 busts without a pass
    dp.hand_total = 8'd17;
    dp.soft_hand  = 1'b1;
    pulse_turn(t);
    push(1'b1, t + LAT);
    at_cycle(t + LAT + 2);
    dp.hand_total = 8'd23;
    dp.soft_hand  = 1'b0;
    deal(d);
    at_cycle(d + LAT - 1);
    chk("t3_decide_done", 32'(dp.done), 32'd0);
    at_cycle(d + LAT);
    chk_status("t3_bust", 1'b0, 1'b1, 1'b1, 1'b0, 3'd3);

    // 4: total stays 4, card cap forces a pass at five cards
    dp.hand_total = 8'd4;
    pulse_turn(t);
    at_cycle(t + 1);
    chk("t4_bust_clr", 32'(dp.bust), 32'd0);
    p = t + LAT;
    for (int k = 0; k < 3; k++) begin
      push(1'b1, p);
      at_cycle(p);
      deal(d);
      p = d + LAT;
    end
    push(1'b0, p);
    at_cycle(p + 1);
    chk_status("t4_cap", 1'b0, 1'b1, 1'b0, 1'b0, 3'd5);

    // 5: no card -> timeout after WLIM clocks, late card ignored
    dp.hand_total = 8'd10;
    pulse_turn(t);
    push(1'b1, t + LAT);
    at_cycle(t + LAT + WLIM - 1);
    chk_status("t5_pre", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    at_cycle(t + LAT + WLIM);
    chk_status("t5_tmo", 1'b0, 1'b1, 1'b0, 1'b1, 3'd2);
    deal(d);
    at_cycle(d + 1);
    chk_status("t5_ign", 1'b0, 1'b1, 1'b0, 1'b1, 3'd2);

    // 5b: card on the expiry clock is accepted
    pulse_turn(t);
    push(1'b1, t + LAT);
    at_cycle(t + LAT + WLIM - 1);
    dp.hand_total = 8'd20;
    deal(d);
    push(1'b0, d + LAT);
    at_cycle(d + 1);
    chk_status("t5b_late", 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    at_cycle(d + LAT + 1);
    chk_status("t5b_end", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);

    // 6: turn_start mid-THINK ignored, reset during WAIT_CARD clears at once
    dp.hand_total = 8'd12;
    pulse_turn(t);
    push(1'b1, t + LAT);
    at_cycle(t + 2);
    pulse_turn(d);
    at_cycle(t + LAT + 2);
    chk_status("t6_wait", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    reset = 1'b0;
    #2;
    chk_status("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    at_cycle(cyc + 2);
    chk_status("t6_rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    dp.hand_total = 8'd19;
    pulse_turn(t);
    push(1'b0, t + LAT);
    at_cycle(t + LAT + 1);
    chk_status("t6_restart", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);

    at_cycle(cyc + 3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
